sseg_scan_mux: RTL

//  Consumes the stopwatch BCD digit outputs and drives a 4-digit, common-anode, time-multiplexed 7-segment display.

---
 rtl/sseg_scan_mux_if.sv | 13 +
 rtl/sseg_scan_mux.sv | 77 +++++++
 2 files changed

// File: rtl/sseg_scan_mux_if.sv
// sseg_scan_mux_if: digit/dp/blank inputs and anode/segment outputs of the 7-segment scanner.
interface sseg_scan_mux_if;
   logic [3:0] d3;
   logic [3:0] d2;
   logic [3:0] d1;
   logic [3:0] d0;
   logic [3:0] dp;
   logic       blank;
   logic [3:0] an;
   logic [7:0] sseg;
   modport master (output d3, d2, d1, d0, dp, blank, input an, sseg);
   modport slave (input d3, d2, d1, d0, dp, blank, output an, sseg);
endinterface

// File: rtl/sseg_scan_mux.sv
// sseg_scan_mux: 4-digit common-anode scan driver with per-frame snapshot and guard interval.
// Optional LEAD_ZERO_BLANK_EN darkens leading zero digits 3..1 of the snapshot.
module sseg_scan_mux #(
   parameter int REFRESH_DIV = 62500,
   parameter int GUARD       = 64
) (
   input logic            clk,
   input logic            res_n,
   sseg_scan_mux_if.slave bus
);
   localparam int CW = $clog2(REFRESH_DIV);
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [1:0]      idx_q, idx_d;
   logic [3:0][3:0] snap_q, snap_d;
   logic [3:0]      snap_dp_q, snap_dp_d;
   logic [3:0]      an_q, an_d;
   logic [7:0]      sseg_q, sseg_d;
   logic [3:0]      lz;
   logic            tick, dark;
   function automatic logic [6:0] seg7(input logic [3:0] v);
      case (v)
         4'h0: return 7'h40;
         4'h1: return 7'h79;
         4'h2: return 7'h24;
         4'h3: return 7'h30;
         4'h4: return 7'h19;
         4'h5: return 7'h12;
         4'h6: return 7'h02;
         4'h7: return 7'h78;
         4'h8: return 7'h00;
         4'h9: return 7'h10;
         4'hA: return 7'h08;
         4'hB: return 7'h03;
         4'hC: return 7'h46;
         4'hD: return 7'h21;
         4'hE: return 7'h06;
         default: return 7'h0E;
      endcase
   endfunction
   always_comb begin
      tick      = cnt_q == CW'(REFRESH_DIV - 1);
      cnt_d     = tick ? '0 : cnt_q + 1'b1;
      idx_d     = tick ? idx_q + 2'd1 : idx_q;
      // frame snapshot at the idx3->0 wrap keeps all four digits coherent
      snap_d    = (tick && idx_q == 2'd3) ? {bus.d3, bus.d2, bus.d1, bus.d0} : snap_q;
      snap_dp_d = (tick && idx_q == 2'd3) ? bus.dp : snap_dp_q;
      lz        = '0;
`ifdef LEAD_ZERO_BLANK_EN
      lz[3]     = snap_q[3] == 4'd0;
      lz[2]     = lz[3] && snap_q[2] == 4'd0;
      lz[1]     = lz[2] && snap_q[1] == 4'd0;
`else
`endif
      dark      = cnt_q < CW'(GUARD) || bus.blank;
      an_d      = dark ? 4'hF : ~(4'b0001 << idx_q);
      sseg_d    = (dark || lz[idx_q]) ? 8'hFF : {~snap_dp_q[idx_q], seg7(snap_q[idx_q])};
   end
   always_ff @(posedge clk) begin
      if (!res_n) begin
         cnt_q     <= '0;
         idx_q     <= '0;
         snap_q    <= '0;
         snap_dp_q <= '0;
         an_q      <= 4'hF;
         sseg_q    <= 8'hFF;
      end else begin
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         snap_q    <= snap_d;
         snap_dp_q <= snap_dp_d;
         an_q      <= an_d;
         sseg_q    <= sseg_d;
      end
   end
   assign bus.an   = an_q;
   assign bus.sseg = sseg_q;
endmodule
